// File: rtl/frogger_gfx_pkg.sv
// Shared graphics constants for the frogger playfield: coordinate widths,
// playfield bounds, palette entries and overlay request encodings.
package frogger_gfx_pkg;

  localparam int XW_DEF      = 10;
  localparam int YW_DEF      = 9;
  localparam int COLOR_W_DEF = 12;

  localparam int FIELD_L_DEF = 20;
  localparam int FIELD_R_DEF = 620;
  localparam int FIELD_T_DEF = 20;
  localparam int FIELD_B_DEF = 460;

  localparam logic [COLOR_W_DEF-1:0] COL_FROG  = 12'h0F0;
  localparam logic [COLOR_W_DEF-1:0] COL_WATER = 12'h00F;
  localparam logic [COLOR_W_DEF-1:0] COL_GRASS = 12'h0A0;
  localparam logic [COLOR_W_DEF-1:0] COL_LINE  = 12'hFFF;
  localparam logic [COLOR_W_DEF-1:0] COL_WIN   = 12'hFF0;
  localparam logic [COLOR_W_DEF-1:0] COL_DEAD  = 12'hF00;
  localparam logic [COLOR_W_DEF-1:0] COL_BG    = 12'h222;

  // 2'b11 is not a distinct request; the compositor draws it as dead.
  typedef enum logic [1:0] {
    OVL_NONE     = 2'b00,
    OVL_WIN      = 2'b01,
    OVL_DEAD     = 2'b10,
    OVL_DEAD_ALT = 2'b11
  } ovl_req_e;

endpackage

// File: rtl/rect_hit.sv
// Combinational inclusive rectangle membership test with enable.
// An inverted rectangle (l > r or t > b) can never report a hit.
module rect_hit #(
  parameter int XW = 10,
  parameter int YW = 9
)(
  input  logic          en,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic [XW-1:0] l,
  input  logic [XW-1:0] r,
  input  logic [YW-1:0] t,
  input  logic [YW-1:0] b,
  output logic          hit
);

  assign hit = en && (x >= l) && (x <= r) && (y >= t) && (y <= b);

endmodule

// File: rtl/layer_compositor.sv
// Two-stage fixed-priority pixel compositor with frame-shadowed sprites and a blinking overlay.
// Build with LAYER_COMPOSITOR_COLLIDE_EN defined to enable the per-frame player collision flag.
module layer_compositor
  import frogger_gfx_pkg::*;
#(
  parameter int NUM_SPRITES = 8,
  parameter int NUM_BANDS   = 4,
  parameter int XW          = XW_DEF,
  parameter int YW          = YW_DEF,
  parameter int COLOR_W     = COLOR_W_DEF,
  parameter int FIELD_L     = FIELD_L_DEF,
  parameter int FIELD_R     = FIELD_R_DEF,
  parameter int FIELD_T     = FIELD_T_DEF,
  parameter int FIELD_B     = FIELD_B_DEF,
  parameter int BLINK_LOG2  = 4
)(
  input  logic                           clk_in,
  input  logic                           reset_in,
  input  logic                           pix_stb,
  input  logic                           frame_start,
  input  logic [XW-1:0]                  x_i,
  input  logic [YW-1:0]                  y_i,
  input  logic [NUM_SPRITES*XW-1:0]      spr_l_i,
  input  logic [NUM_SPRITES*XW-1:0]      spr_r_i,
  input  logic [NUM_SPRITES*YW-1:0]      spr_t_i,
  input  logic [NUM_SPRITES*YW-1:0]      spr_b_i,
  input  logic [NUM_SPRITES-1:0]         spr_en_i,
  input  logic [NUM_SPRITES*COLOR_W-1:0] spr_color_i,
  input  logic [NUM_BANDS*YW-1:0]        band_t_i,
  input  logic [NUM_BANDS*YW-1:0]        band_b_i,
  input  logic [NUM_BANDS*COLOR_W-1:0]   band_color_i,
  input  logic [COLOR_W-1:0]             bg_color_i,
  input  logic [1:0]                     ovl_req_i,
  input  logic                           ovl_mask_i,
  input  logic [2*COLOR_W-1:0]           ovl_color_i,
  output logic [COLOR_W-1:0]             rgb_o,
  output logic                           pix_valid_o,
  output logic                           collision_o
);

  localparam int CNT_W = BLINK_LOG2 + 1;
  localparam logic [XW-1:0] FL = XW'(FIELD_L);
  localparam logic [XW-1:0] FR = XW'(FIELD_R);
  localparam logic [YW-1:0] FT = YW'(FIELD_T);
  localparam logic [YW-1:0] FB = YW'(FIELD_B);

  logic [NUM_SPRITES*XW-1:0]      sh_l, sh_r;
  logic [NUM_SPRITES*YW-1:0]      sh_t, sh_b;
  logic [NUM_SPRITES-1:0]         sh_en;
  logic [NUM_SPRITES*COLOR_W-1:0] sh_color;

  logic                   in_field;
  logic [NUM_SPRITES-1:0] spr_hit;
  logic [NUM_BANDS-1:0]   band_hit;

  logic                   in_field_q;
  logic [NUM_SPRITES-1:0] spr_hit_q;
  logic [NUM_BANDS-1:0]   band_hit_q;
  logic                   mask_q;
  logic [1:0]             stb_seen;

  logic [CNT_W-1:0]   frame_cnt;
  logic               blink_on;
  logic               spr_any, band_any;
  logic [COLOR_W-1:0] spr_col, band_col, ovl_col, rgb_next;

  // Sprite geometry only changes at frame boundaries so a frame never tears.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      sh_l     <= '0;
      sh_r     <= '0;
      sh_t     <= '0;
      sh_b     <= '0;
      sh_en    <= '0;
      sh_color <= '0;
    end else if (frame_start) begin
      sh_l     <= spr_l_i;
      sh_r     <= spr_r_i;
      sh_t     <= spr_t_i;
      sh_b     <= spr_b_i;
      sh_en    <= spr_en_i;
      sh_color <= spr_color_i;
    end
  end

  assign in_field = (x_i >= FL) && (x_i <= FR) && (y_i >= FT) && (y_i <= FB);

  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_spr
    rect_hit #(.XW(XW), .YW(YW)) u_hit (
      .en (sh_en[i]),
      .x  (x_i),
      .y  (y_i),
      .l  (sh_l[i*XW +: XW]),
      .r  (sh_r[i*XW +: XW]),
      .t  (sh_t[i*YW +: YW]),
      .b  (sh_b[i*YW +: YW]),
      .hit(spr_hit[i])
    );
  end

  for (genvar i = 0; i < NUM_BANDS; i++) begin : g_band
    rect_hit #(.XW(XW), .YW(YW)) u_hit (
      .en (1'b1),
      .x  (x_i),
      .y  (y_i),
      .l  (FL),
      .r  (FR),
      .t  (band_t_i[i*YW +: YW]),
      .b  (band_b_i[i*YW +: YW]),
      .hit(band_hit[i])
    );
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      in_field_q <= 1'b0;
      spr_hit_q  <= '0;
      band_hit_q <= '0;
      mask_q     <= 1'b0;
      stb_seen   <= '0;
    end else if (pix_stb) begin
      in_field_q <= in_field;
      spr_hit_q  <= spr_hit;
      band_hit_q <= band_hit;
      mask_q     <= ovl_mask_i;
      stb_seen   <= {stb_seen[0], 1'b1};
    end
  end

  // Holding the counter at zero while idle makes every new overlay start visible.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      frame_cnt <= '0;
    end else if (ovl_req_i == OVL_NONE) begin
      frame_cnt <= '0;
    end else if (frame_start) begin
      frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

  assign blink_on = ~frame_cnt[BLINK_LOG2];

  // Descending scans so the lowest-index hit is the last write and wins.
  always_comb begin
    spr_any  = 1'b0;
    spr_col  = '0;
    band_any = 1'b0;
    band_col = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (spr_hit_q[i]) begin
        spr_any = 1'b1;
        spr_col = sh_color[i*COLOR_W +: COLOR_W];
      end
    end
    for (int i = NUM_BANDS - 1; i >= 0; i--) begin
      if (band_hit_q[i]) begin
        band_any = 1'b1;
        band_col = band_color_i[i*COLOR_W +: COLOR_W];
      end
    end
    ovl_col = (ovl_req_i == OVL_WIN) ? ovl_color_i[COLOR_W-1:0]
                                     : ovl_color_i[2*COLOR_W-1:COLOR_W];
    if (!in_field_q)
      rgb_next = '0;
    else if (spr_any)
      rgb_next = spr_col;
    else if (band_any)
      rgb_next = band_col;
    else if ((ovl_req_i != OVL_NONE) && blink_on && mask_q)
      rgb_next = ovl_col;
    else
      rgb_next = bg_color_i;
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in)
      rgb_o <= '0;
    else if (pix_stb)
      rgb_o <= rgb_next;
  end

  assign pix_valid_o = stb_seen[1];

`ifdef LAYER_COMPOSITOR_COLLIDE_EN
  logic coll_acc;
  logic coll_hit;

  assign coll_hit = pix_stb && in_field_q && spr_hit_q[0] && (|spr_hit_q[NUM_SPRITES-1:1]);

  // A hit coinciding with frame_start belongs to the frame that is starting.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      coll_acc    <= 1'b0;
      collision_o <= 1'b0;
    end else if (frame_start) begin
      collision_o <= coll_acc;
      coll_acc    <= coll_hit;
    end else if (coll_hit) begin
      coll_acc    <= 1'b1;
    end
  end
`else
  assign collision_o = 1'b0;
`endif

endmodule

// File: tb/tb_layer_compositor.sv
// Self-checking bench for layer_compositor: directed edge/priority/shadow/blink/collision
// steps followed by randomized frames, all checked against a behavioural picture model.
module tb_layer_compositor;

  localparam int NS = 8;
  localparam int NB = 4;
  localparam int XW = 10;
  localparam int YW = 9;
  localparam int CW = 12;

  logic              clk_in = 1'b0;
  logic              reset_in;
  logic              pix_stb;
  logic              frame_start;
  logic [XW-1:0]     x_i;
  logic [YW-1:0]     y_i;
  logic [NS*XW-1:0]  spr_l_i, spr_r_i;
  logic [NS*YW-1:0]  spr_t_i, spr_b_i;
  logic [NS-1:0]     spr_en_i;
  logic [NS*CW-1:0]  spr_color_i;
  logic [NB*YW-1:0]  band_t_i, band_b_i;
  logic [NB*CW-1:0]  band_color_i;
  logic [CW-1:0]     bg_color_i;
  logic [1:0]        ovl_req_i;
  logic              ovl_mask_i;
  logic [2*CW-1:0]   ovl_color_i;
  logic [CW-1:0]     rgb_o;
  logic              pix_valid_o;
  logic              collision_o;

  layer_compositor #(.NUM_SPRITES(NS), .NUM_BANDS(NB)) dut (
    .clk_in      (clk_in),
    .reset_in    (reset_in),
    .pix_stb     (pix_stb),
    .frame_start (frame_start),
    .x_i         (x_i),
    .y_i         (y_i),
    .spr_l_i     (spr_l_i),
    .spr_r_i     (spr_r_i),
    .spr_t_i     (spr_t_i),
    .spr_b_i     (spr_b_i),
    .spr_en_i    (spr_en_i),
    .spr_color_i (spr_color_i),
    .band_t_i    (band_t_i),
    .band_b_i    (band_b_i),
    .band_color_i(band_color_i),
    .bg_color_i  (bg_color_i),
    .ovl_req_i   (ovl_req_i),
    .ovl_mask_i  (ovl_mask_i),
    .ovl_color_i (ovl_color_i),
    .rgb_o       (rgb_o),
    .pix_valid_o (pix_valid_o),
    .collision_o (collision_o)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  // Requested sprite state (what is on the ports) and the frame's latched copy.
  int          cl[NS], cr[NS], ct[NS], cb[NS];
  bit          cen[NS];
  logic [11:0] ccol[NS];
  int          sl[NS], sr[NS], st[NS], sb[NS];
  bit          sen[NS];
  logic [11:0] scol[NS];
  int          bt[NB], bb[NB];
  logic [11:0] bcol[NB];
  logic [11:0] bg, win_c, dead_c;
  int          req;
  bit          mask;
  int          frames;
  int          nstb;
  bit          acc, coll_exp;
  logic [11:0] prev_exp;
  bit          prev_chk, have_prev;
  string       prev_tag;

  function automatic bit spr_on(int i, int px, int py);
    return sen[i] && px >= sl[i] && px <= sr[i] && py >= st[i] && py <= sb[i];
  endfunction

  function automatic bit on_field(int px, int py);
    return px >= 20 && px <= 620 && py >= 20 && py <= 460;
  endfunction

  function automatic logic [11:0] ref_color(int px, int py);
    if (!on_field(px, py)) return 12'h000;
    for (int i = 0; i < NS; i++) if (spr_on(i, px, py)) return scol[i];
    for (int j = 0; j < NB; j++) if (py >= bt[j] && py <= bb[j]) return bcol[j];
    if (req != 0 && (frames % 32) < 16 && mask) return (req == 1) ? win_c : dead_c;
    return bg;
  endfunction

  function automatic bit ref_coll(int px, int py);
    bit other = 1'b0;
    for (int i = 1; i < NS; i++) if (spr_on(i, px, py)) other = 1'b1;
    return on_field(px, py) && spr_on(0, px, py) && other;
  endfunction

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_all();
    for (int i = 0; i < NS; i++) begin
      spr_l_i[i*XW +: XW]     = XW'(cl[i]);
      spr_r_i[i*XW +: XW]     = XW'(cr[i]);
      spr_t_i[i*YW +: YW]     = YW'(ct[i]);
      spr_b_i[i*YW +: YW]     = YW'(cb[i]);
      spr_en_i[i]             = cen[i];
      spr_color_i[i*CW +: CW] = ccol[i];
    end
    for (int j = 0; j < NB; j++) begin
      band_t_i[j*YW +: YW]     = YW'(bt[j]);
      band_b_i[j*YW +: YW]     = YW'(bb[j]);
      band_color_i[j*CW +: CW] = bcol[j];
    end
    bg_color_i  = bg;
    ovl_color_i = {dead_c, win_c};
    ovl_req_i   = 2'(req);
    if (req == 0) frames = 0;
  endtask

  // One strobed pixel; the colour of the previous pixel is due right after this strobe.
  task automatic pixel(input int px, input int py, input string tag, input bit chk);
    @(posedge clk_in); #1;
    x_i = XW'(px); y_i = YW'(py); ovl_mask_i = mask; pix_stb = 1'b1;
    @(posedge clk_in); #1;
    pix_stb = 1'b0;
    nstb++;
    if (have_prev && prev_chk) check(prev_tag, rgb_o, prev_exp);
    check({tag, "/valid"}, {11'b0, pix_valid_o}, {11'b0, (nstb >= 2)});
    prev_exp  = ref_color(px, py);
    prev_chk  = chk;
    prev_tag  = tag;
    have_prev = 1'b1;
    if (ref_coll(px, py)) acc = 1'b1;
    repeat (2) @(posedge clk_in);
  endtask

  task automatic pulse_frame(input string tag);
    bit expc;
    @(posedge clk_in); #1 frame_start = 1'b1;
    @(posedge clk_in); #1 frame_start = 1'b0;
    for (int i = 0; i < NS; i++) begin
      sl[i] = cl[i]; sr[i] = cr[i]; st[i] = ct[i]; sb[i] = cb[i];
      sen[i] = cen[i]; scol[i] = ccol[i];
    end
    frames   = (req == 0) ? 0 : frames + 1;
    coll_exp = acc;
    acc      = 1'b0;
    expc     = coll_exp;
`ifndef LAYER_COMPOSITOR_COLLIDE_EN
    expc = 1'b0;
`endif
    check({tag, "/collision"}, {11'b0, collision_o}, {11'b0, expc});
  endtask

  task automatic frame(input string tag);
    pixel(0, 0, "flush", 1'b0);
    pulse_frame(tag);
  endtask

  initial begin
    reset_in = 1'b1; pix_stb = 1'b0; frame_start = 1'b0;
    x_i = '0; y_i = '0; ovl_mask_i = 1'b0;
    for (int i = 0; i < NS; i++) begin
      cl[i] = 0; cr[i] = 0; ct[i] = 0; cb[i] = 0; cen[i] = 1'b0;
      ccol[i] = 12'($urandom);
      sl[i] = 0; sr[i] = 0; st[i] = 0; sb[i] = 0; sen[i] = 1'b0; scol[i] = '0;
    end
    for (int j = 0; j < NB; j++) begin
      bt[j] = 1; bb[j] = 0; bcol[j] = 12'($urandom);
    end
    bg = 12'($urandom); win_c = 12'($urandom); dead_c = 12'($urandom);
    req = 0; mask = 1'b0; frames = 0; nstb = 0; acc = 1'b0; coll_exp = 1'b0;
    have_prev = 1'b0; prev_chk = 1'b0; prev_exp = '0; prev_tag = "";
    drive_all();

    // Reset state
    repeat (3) @(posedge clk_in); #1;
    check("rst_rgb", rgb_o, 12'h000);
    check("rst_valid", {11'b0, pix_valid_o}, 12'h000);
    check("rst_coll", {11'b0, collision_o}, 12'h000);
    @(posedge clk_in); #1 reset_in = 1'b0;
    pulse_frame("rst_frame");
    pixel(100, 100, "rst_px", 1'b1);
    check("rst_rgb_first_stb", rgb_o, 12'h000);
    pixel(100, 101, "rst_px2", 1'b1);

    // Field edges
    frame("edge_frame");
    pixel(19, 100, "edge_x19", 1'b1);
    pixel(20, 100, "edge_x20", 1'b1);
    pixel(620, 100, "edge_x620", 1'b1);
    pixel(621, 100, "edge_x621", 1'b1);
    pixel(100, 19, "edge_y19", 1'b1);
    pixel(100, 20, "edge_y20", 1'b1);
    pixel(100, 460, "edge_y460", 1'b1);
    pixel(100, 461, "edge_y461", 1'b1);
    frame("edge_end");

    // Priority
    cl[0] = 100; cr[0] = 120; ct[0] = 100; cb[0] = 120; cen[0] = 1'b1; ccol[0] = 12'h0F0;
    cl[1] = 110; cr[1] = 130; ct[1] = 100; cb[1] = 120; cen[1] = 1'b1; ccol[1] = 12'hF00;
    bt[0] = 90; bb[0] = 130; bcol[0] = 12'h00F;
    drive_all();
    frame("prio_frame");
    pixel(115, 110, "prio_s0", 1'b1);
    pixel(125, 110, "prio_s1", 1'b1);
    pixel(140, 110, "prio_band", 1'b1);
    pixel(100, 100, "prio_s0_corner", 1'b1);
    pixel(130, 120, "prio_s1_corner", 1'b1);
    pixel(131, 120, "prio_band_edge", 1'b1);
    pixel(140, 131, "prio_bg", 1'b1);

    // Shadowing
    cl[0] = 200; cen[1] = 1'b0;
    drive_all();
    pixel(115, 110, "shadow_old", 1'b1);
    frame("shadow_frame");
    pixel(115, 110, "shadow_new", 1'b1);
    frame("shadow_end");

    // Collision
    cl[0] = 100;
    cl[2] = 120; cr[2] = 140; ct[2] = 100; cb[2] = 120; cen[2] = 1'b1; ccol[2] = 12'($urandom);
    drive_all();
    frame("coll_arm");
    pixel(120, 110, "coll_px", 1'b1);
    pixel(50, 50, "coll_quiet", 1'b1);
    frame("coll_set");
    pixel(50, 50, "coll_after", 1'b1);
    frame("coll_clear");

    // Blink
    for (int i = 0; i < NS; i++) cen[i] = 1'b0;
    for (int j = 0; j < NB; j++) begin bt[j] = 1; bb[j] = 0; end
    drive_all();
    frame("blink_prep");
    req = 1; mask = 1'b1;
    drive_all();
    for (int f = 0; f <= 32; f++) begin
      pixel(300, 300, $sformatf("blink_f%0d", f), 1'b1);
      frame("blink");
    end
    req = 2; drive_all();
    pixel(300, 300, "ovl_dead", 1'b1);
    mask = 1'b0;
    pixel(301, 300, "ovl_nomask", 1'b1);
    frame("ovl_dead_end");
    req = 3; mask = 1'b1; drive_all();
    pixel(300, 300, "ovl_req3", 1'b1);
    frame("ovl_req3_end");
    req = 0; drive_all();
    pixel(300, 300, "ovl_off", 1'b1);
    frame("ovl_off_end");

    // Randomized frames
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NS; i++) begin
        cl[i] = $urandom_range(0, 639); cr[i] = cl[i] + $urandom_range(0, 80);
        ct[i] = $urandom_range(0, 479); cb[i] = ct[i] + $urandom_range(0, 30);
        if ($urandom_range(0, 5) == 0 && cl[i] > 0) cr[i] = cl[i] - 1;
        if ($urandom_range(0, 5) == 0 && ct[i] > 0) cb[i] = ct[i] - 1;
        cen[i]  = ($urandom_range(0, 3) != 0);
        ccol[i] = 12'($urandom);
      end
      for (int j = 0; j < NB; j++) begin
        bt[j] = $urandom_range(0, 479); bb[j] = bt[j] + $urandom_range(0, 30);
        bcol[j] = 12'($urandom);
      end
      req = $urandom_range(0, 3);
      drive_all();
      frame("rnd_frame");
      for (int p = 0; p < 40; p++) begin
        int px, py, k;
        mask = 1'($urandom);
        if ($urandom_range(0, 1) == 1) begin
          k  = $urandom_range(0, NS - 1);
          px = sl[k] + $urandom_range(0, 10);
          py = st[k] + $urandom_range(0, 10);
        end else begin
          px = $urandom_range(0, 639);
          py = $urandom_range(0, 479);
        end
        pixel(px, py, $sformatf("rnd%0d_p%0d", r, p), 1'b1);
      end
      frame("rnd_end");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/layer_compositor.md
Name: layer_compositor

Overview:
- Parametrised pixel compositor for the VGA playfield.
- Takes the current pixel X/Y from the 640x480 timing generator, the rectangles of NUM_SPRITES moving objects, and NUM_BANDS static horizontal bands (water, grass, lane lines).
- Produces a registered 12-bit RGB value through a fixed-priority, 2-stage pipeline.
- Also supplies frame-coherent sprite shadowing, a blinking full-field overlay (win/game-over), and a per-frame player-collision flag for the game-state logic.

Parameters:
- NUM_SPRITES, 8, number of sprite channels; index 0 = player, highest priority.
- NUM_BANDS, 4, number of full-width static bands.
- XW, 10, X coordinate width.
- YW, 9, Y coordinate width.
- COLOR_W, 12, RGB width (4:4:4).
- FIELD_L / FIELD_R / FIELD_T / FIELD_B, 20 / 620 / 20 / 460, inclusive playfield bounds.
- BLINK_LOG2, 4, overlay toggles every 2^BLINK_LOG2 frames.

Ports:
- clk_in  in  1  system clock (100 MHz).
- reset_in  in  1  asynchronous, active-high reset.
- pix_stb  in  1  pixel enable (25 MHz strobe); the pipeline advances only when it is high.
- frame_start  in  1  one-cycle pulse at the start of vertical blanking.
- x_i  in  XW  current pixel X.
- y_i  in  YW  current pixel Y.
- spr_l_i / spr_r_i  in  NUM_SPRITES*XW  packed inclusive left/right edges.
- spr_t_i / spr_b_i  in  NUM_SPRITES*YW  packed inclusive top/bottom edges.
- spr_en_i  in  NUM_SPRITES  per-sprite enable.
- spr_color_i  in  NUM_SPRITES*COLOR_W  per-sprite colour.
- band_t_i / band_b_i  in  NUM_BANDS*YW  band vertical extents (band spans FIELD_L..FIELD_R).
- band_color_i  in  NUM_BANDS*COLOR_W  band colours.
- bg_color_i  in  COLOR_W  playfield background colour.
- ovl_req_i  in  2  00 none, 01 win, 10 dead, 11 treated as dead.
- ovl_mask_i  in  1  combinational mask bit for the current pixel (overlay shape).
- ovl_color_i  in  2*COLOR_W  {dead colour, win colour}.
- rgb_o  out  COLOR_W  pixel colour.
- pix_valid_o  out  1  rgb_o corresponds to the pixel presented 2 strobes earlier.
- collision_o  out  1  player overlapped any enabled sprite during the last frame.

Behaviour:
- Reset: all shadow registers and pipeline registers clear to 0; rgb_o=0, pix_valid_o=0, collision_o=0, frame counter=0.
- Shadowing: on frame_start, latch spr_* and spr_en_i into the shadow registers. All comparisons use shadow values only, so there is no tearing mid-frame. Before the first frame_start after reset, all sprites are treated as disabled.
- Stage 1 (on pix_stb):
  - register in_field = X/Y inside FIELD bounds (inclusive).
  - register sprite hit vector: spr_hit[i] = en & L<=x<=R & T<=y<=B.
  - register band hit vector (inclusive).
  - register ovl_mask_i.
- Stage 2 (on pix_stb), first match wins:
  - outside field -> 0;
  - lowest-index sprite hit -> its colour;
  - lowest-index band hit -> its colour;
  - overlay active & blink phase high & mask -> overlay colour;
  - otherwise bg_color_i.
- Latency: exactly 2 pix_stb-qualified cycles. pix_valid_o is high once 2 strobes have occurred since reset and stays high; outputs hold between strobes.
- Degenerate rectangles: L>R or T>B gives an empty rectangle (no hit). All comparisons are unsigned.
- Blink: a BLINK_LOG2+1-bit frame counter increments on frame_start and wraps. The phase is its MSB. When ovl_req_i is 00, the counter resets to 0, so the overlay always starts visible.
- Collision:
  - a sticky accumulator sets when stage-1 spr_hit[0] & |spr_hit[NUM_SPRITES-1:1] & in_field.
  - on frame_start, collision_o <= accumulator and the accumulator clears.
  - if a hit and frame_start coincide, the hit counts toward the new frame.
  - collision_o stays constant for a full frame.
- Reset mid-frame: all state returns to its reset values immediately; drawing resumes at the next frame_start.

Optional Feature:
- LAYER_COMPOSITOR_COLLIDE_EN.
- Defined: collision accumulator and collision_o behave as described above.
- Undefined: the accumulator logic is removed and collision_o is tied to 0. Colour output is unchanged.

Decomposition:
- Package frogger_gfx_pkg:
  - XW, YW, COLOR_W defaults;
  - FIELD_* bounds;
  - named colour constants (COL_FROG, COL_WATER, COL_GRASS, COL_LINE, COL_WIN, COL_DEAD, COL_BG);
  - ovl_req encodings.
- Sub-module rect_hit: combinational inclusive rectangle test with enable. It is instantiated per sprite and per band (band L/R tied to FIELD bounds).

Test Plan:
- Reset: hold reset_in, then release; drive frame_start and pixel (100,100) with all strobes -> rgb_o=0, pix_valid_o=0 before the 2nd strobe; collision_o=0.
- Latency and field edge:
  - after frame_start, present pixels (19,100), (20,100), (620,100), (621,100) on consecutive strobes with no sprites;
  - rgb_o follows 2 strobes later: 0, bg, bg, 0.
- Priority:
  - sprite0 at (100..120, 100..120) in 0x0F0 and sprite1 at (110..130, 100..120) in 0xF00; band0 rows 90..130 in 0x00F;
  - pixel (115,110) -> 0x0F0; (125,110) -> 0xF00; (140,110) -> 0x00F.
- Shadowing: change sprite0 L from 100 to 200 mid-frame -> pixel (115,110) still shows 0x0F0 until the next frame_start, then shows the band colour.
- Blink: set ovl_req=01, mask=1, no sprites or bands, BLINK_LOG2=4 -> overlay colour for frames 0–15, bg for frames 16–31, overlay again at frame 32.
- Collision (macro defined): overlap sprite0 and sprite2 for one pixel in frame N -> collision_o=1 after the frame_start ending frame N; 0 after the next frame_start if there is no further overlap. With the macro undefined -> collision_o stays 0.
